// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with a data-memory timeout trap.
// Optional retired-instruction counter enabled by defining SEQ_PERF_CNT_EN.
module cpu_sequencer #(
   parameter int unsigned TMO_W = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic             i_dec_mem_rd,
   input  logic             i_dec_mem_wr,
   input  logic             i_dec_branch,
   input  logic             i_dec_halt,
   input  logic             i_branch_taken,
   input  logic             i_mem_ready,
   output logic             o_ir_load,
   output logic             o_pc_inc,
   output logic             o_pc_ld,
   output logic             o_reg_wr_en,
   output logic             o_mem_rd_req,
   output logic             o_mem_wr_req,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   output logic [2:0]       o_state,
   output logic [CNT_W-1:0] o_ret_cnt
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   // Last wait count before the trap: the cycle on which tmo would reach 2**TMO_W-1.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);

   state_t           r_state;
   state_t           w_next;
   logic [TMO_W-1:0] r_tmo;
   logic             w_store_done;

   assign w_store_done = (r_state == S_MEM) & i_mem_ready & i_dec_mem_wr & ~i_dec_mem_rd;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Memory-wait timeout counter, cleared on entry to MEM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 r_tmo <= '0;
      else if (r_state == S_EXEC)                 r_tmo <= '0;
      else if (r_state == S_MEM && !i_mem_ready)  r_tmo <= r_tmo + TMO_W'(1);
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (i_start) w_next = S_FETCH;
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: begin
            if (i_dec_halt)                       w_next = S_HALT;
            else if (i_dec_mem_rd & i_dec_mem_wr) w_next = S_ERR;
            else                                  w_next = S_EXEC;
         end
         S_EXEC:   w_next = (i_dec_mem_rd | i_dec_mem_wr) ? S_MEM : S_WB;
         S_MEM: begin
            if (i_mem_ready)             w_next = w_store_done ? S_FETCH : S_WB;
            else if (r_tmo == TMO_LAST)  w_next = S_ERR;
         end
         S_WB:     w_next = S_FETCH;
         S_HALT:   if (!i_start) w_next = S_IDLE;
         S_ERR:    w_next = S_ERR;
         default:  w_next = S_IDLE;
      endcase
   end

   // Moore strobes; only the MEM/WB PC strobes look at the handshake/branch inputs
   always_comb begin
      o_ir_load    = 1'b0;
      o_pc_inc     = 1'b0;
      o_pc_ld      = 1'b0;
      o_reg_wr_en  = 1'b0;
      o_mem_rd_req = 1'b0;
      o_mem_wr_req = 1'b0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      o_err        = 1'b0;
      case (r_state)
         S_FETCH: begin
            o_ir_load = 1'b1;
            o_busy    = 1'b1;
         end
         S_DECODE, S_EXEC: o_busy = 1'b1;
         S_MEM: begin
            o_busy       = 1'b1;
            o_mem_rd_req = i_dec_mem_rd;
            o_mem_wr_req = i_dec_mem_wr;
            o_pc_inc     = w_store_done;
         end
         S_WB: begin
            o_busy      = 1'b1;
            o_reg_wr_en = ~i_dec_branch;
            o_pc_ld     = i_dec_branch & i_branch_taken;
            o_pc_inc    = ~(i_dec_branch & i_branch_taken);
         end
         S_HALT:  o_done = 1'b1;
         S_ERR:   o_err  = 1'b1;
         default: ;
      endcase
   end

   assign o_state = r_state;

`ifdef SEQ_PERF_CNT_EN
   logic [CNT_W-1:0] r_ret_cnt;
   logic             w_retire;

   assign w_retire = (r_state == S_WB) | w_store_done;

   // Retired-instruction counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_ret_cnt <= '0;
      else if (w_retire) r_ret_cnt <= r_ret_cnt + CNT_W'(1);
   end

   assign o_ret_cnt = r_ret_cnt;
`else
   assign o_ret_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: instruction classes, memory waits, timeout trap, halt, reset.
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mem_rd = 1'b0, mem_wr = 1'b0, branch = 1'b0, halt = 1'b0;
   logic        taken = 1'b0, ready = 1'b0;
   logic        ir_load, pc_inc, pc_ld, reg_wr_en, mem_rd_req, mem_wr_req;
   logic        busy, done, err;
   logic [2:0]  state;
   logic [15:0] ret_cnt;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_ret = 16'd0;

`ifdef SEQ_PERF_CNT_EN
   localparam int PERF = 1;
`else
   localparam int PERF = 0;
`endif

   // {ir_load, pc_inc, pc_ld, reg_wr_en, rd_req, wr_req, busy, done, err, state}
   logic [11:0] obs;
   assign obs = {ir_load, pc_inc, pc_ld, reg_wr_en, mem_rd_req, mem_wr_req,
                 busy, done, err, state};

   localparam logic [11:0] V_IDLE   = {9'b000000000, 3'd0};
   localparam logic [11:0] V_FETCH  = {9'b100000100, 3'd1};
   localparam logic [11:0] V_DECODE = {9'b000000100, 3'd2};
   localparam logic [11:0] V_EXEC   = {9'b000000100, 3'd3};
   localparam logic [11:0] V_WB_ALU = {9'b010100100, 3'd5};
   localparam logic [11:0] V_WB_BT  = {9'b001000100, 3'd5};
   localparam logic [11:0] V_WB_BN  = {9'b010000100, 3'd5};
   localparam logic [11:0] V_MEM_LD = {9'b000010100, 3'd4};
   localparam logic [11:0] V_MEM_ST = {9'b000001100, 3'd4};
   localparam logic [11:0] V_ST_RDY = {9'b010001100, 3'd4};
   localparam logic [11:0] V_HALT   = {9'b000000010, 3'd6};
   localparam logic [11:0] V_ERR    = {9'b000000001, 3'd7};

   cpu_sequencer #(.TMO_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(start),
      .i_dec_mem_rd(mem_rd), .i_dec_mem_wr(mem_wr), .i_dec_branch(branch),
      .i_dec_halt(halt), .i_branch_taken(taken), .i_mem_ready(ready),
      .o_ir_load(ir_load), .o_pc_inc(pc_inc), .o_pc_ld(pc_ld),
      .o_reg_wr_en(reg_wr_en), .o_mem_rd_req(mem_rd_req), .o_mem_wr_req(mem_wr_req),
      .o_busy(busy), .o_done(done), .o_err(err), .o_state(state), .o_ret_cnt(ret_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      total++;
      if (obs !== V_IDLE || ret_cnt !== 16'd0) begin
         bad++; $display("FAIL reset: obs=%b ret=%0d want obs=%b ret=0", obs, ret_cnt, V_IDLE);
      end
      #4 rst_n = 1'b1;
   endtask

   task automatic test_alu();
      start = 1'b1;
      step();
      total++;
      if (obs !== V_FETCH) begin bad++; $display("FAIL alu_fetch: obs=%b want %b", obs, V_FETCH); end
      start = 1'b0;
      step();
      total++;
      if (obs !== V_DECODE) begin bad++; $display("FAIL alu_decode: obs=%b want %b", obs, V_DECODE); end
      step();
      total++;
      if (obs !== V_EXEC) begin bad++; $display("FAIL alu_exec: obs=%b want %b", obs, V_EXEC); end
      step();
      total++;
      if (obs !== V_WB_ALU) begin bad++; $display("FAIL alu_wb: obs=%b want %b", obs, V_WB_ALU); end
      step();
      exp_ret = 16'(exp_ret + PERF);
      total++;
      if (obs !== V_FETCH || ret_cnt !== exp_ret) begin
         bad++; $display("FAIL alu_retire: obs=%b ret=%0d want %b ret=%0d", obs, ret_cnt, V_FETCH, exp_ret);
      end
   endtask

   task automatic test_load();
      int ncyc = 1;
      int nreq = 0;
      mem_rd = 1'b1;
      step(); step(); step(); ncyc += 3;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (obs !== V_MEM_LD) begin bad++; $display("FAIL load_wait%0d: obs=%b want %b", i, obs, V_MEM_LD); end
         if (mem_rd_req) nreq++;
         step(); ncyc++;
      end
      ready = 1'b1;
      #1;
      total++;
      if (obs !== V_MEM_LD) begin bad++; $display("FAIL load_ready: obs=%b want %b", obs, V_MEM_LD); end
      if (mem_rd_req) nreq++;
      step(); ncyc++;
      ready = 1'b0;
      #1;
      total++;
      if (obs !== V_WB_ALU) begin bad++; $display("FAIL load_wb: obs=%b want %b", obs, V_WB_ALU); end
      step();
      exp_ret = 16'(exp_ret + PERF);
      total++;
      if (obs !== V_FETCH || ncyc !== 8 || nreq !== 4 || ret_cnt !== exp_ret) begin
         bad++; $display("FAIL load_total: obs=%b cyc=%0d req=%0d ret=%0d want cyc=8 req=4 ret=%0d",
                         obs, ncyc, nreq, ret_cnt, exp_ret);
      end
      mem_rd = 1'b0;
   endtask

   task automatic test_branch();
      branch = 1'b1;
      taken  = 1'b1;
      step(); step(); step();
      total++;
      if (obs !== V_WB_BT) begin bad++; $display("FAIL br_taken: obs=%b want %b", obs, V_WB_BT); end
      step();
      taken = 1'b0;
      step(); step(); step();
      total++;
      if (obs !== V_WB_BN) begin bad++; $display("FAIL br_not_taken: obs=%b want %b", obs, V_WB_BN); end
      step();
      exp_ret = 16'(exp_ret + 2 * PERF);
      total++;
      if (obs !== V_FETCH || ret_cnt !== exp_ret) begin
         bad++; $display("FAIL br_retire: obs=%b ret=%0d want %b ret=%0d", obs, ret_cnt, V_FETCH, exp_ret);
      end
      branch = 1'b0;
   endtask

   task automatic test_store();
      mem_wr = 1'b1;
      step(); step(); step();
      total++;
      if (obs !== V_MEM_ST) begin bad++; $display("FAIL store_wait: obs=%b want %b", obs, V_MEM_ST); end
      step();
      ready = 1'b1;
      #1;
      total++;
      if (obs !== V_ST_RDY) begin bad++; $display("FAIL store_ready: obs=%b want %b", obs, V_ST_RDY); end
      step();
      ready  = 1'b0;
      exp_ret = 16'(exp_ret + PERF);
      #1;
      total++;
      if (obs !== V_FETCH || ret_cnt !== exp_ret) begin
         bad++; $display("FAIL store_retire: obs=%b ret=%0d want %b ret=%0d", obs, ret_cnt, V_FETCH, exp_ret);
      end
      mem_wr = 1'b0;
   endtask

   task automatic test_halt();
      halt   = 1'b1;
      mem_wr = 1'b1;
      start  = 1'b1;
      ready  = 1'b1;
      step();
      total++;
      if (obs !== V_DECODE) begin bad++; $display("FAIL halt_decode: obs=%b want %b", obs, V_DECODE); end
      step();
      total++;
      if (obs !== V_HALT) begin bad++; $display("FAIL halt_enter: obs=%b want %b", obs, V_HALT); end
      step();
      total++;
      if (obs !== V_HALT) begin bad++; $display("FAIL halt_hold: obs=%b want %b", obs, V_HALT); end
      start = 1'b0;
      ready = 1'b0;
      step();
      total++;
      if (obs !== V_IDLE || ret_cnt !== exp_ret) begin
         bad++; $display("FAIL halt_exit: obs=%b ret=%0d want %b ret=%0d", obs, ret_cnt, V_IDLE, exp_ret);
      end
      halt   = 1'b0;
      mem_wr = 1'b0;
   endtask

   task automatic test_decode_err();
      start = 1'b1;
      step();
      start  = 1'b0;
      mem_rd = 1'b1;
      mem_wr = 1'b1;
      step(); step();
      total++;
      if (obs !== V_ERR) begin bad++; $display("FAIL dec_err: obs=%b want %b", obs, V_ERR); end
      start = 1'b1;
      step();
      total++;
      if (obs !== V_ERR) begin bad++; $display("FAIL dec_err_hold: obs=%b want %b", obs, V_ERR); end
      start  = 1'b0;
      mem_rd = 1'b0;
      mem_wr = 1'b0;
      rst_n  = 1'b0;
      #1;
      exp_ret = 16'd0;
      total++;
      if (obs !== V_IDLE || ret_cnt !== 16'd0) begin
         bad++; $display("FAIL err_reset: obs=%b ret=%0d want %b ret=0", obs, ret_cnt, V_IDLE);
      end
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_mem();
      start = 1'b1;
      step();
      start  = 1'b0;
      mem_rd = 1'b1;
      step(); step(); step();
      total++;
      if (obs !== V_MEM_LD) begin bad++; $display("FAIL mid_mem_pre: obs=%b want %b", obs, V_MEM_LD); end
      rst_n = 1'b0;
      #1;
      total++;
      if (obs !== V_IDLE || ret_cnt !== 16'd0) begin
         bad++; $display("FAIL mid_mem_reset: obs=%b ret=%0d want %b ret=0", obs, ret_cnt, V_IDLE);
      end
      mem_rd = 1'b0;
      #1 rst_n = 1'b1;
   endtask

   task automatic test_timeout();
      int n    = 0;
      int nreq = 0;
      start = 1'b1;
      step();
      start  = 1'b0;
      mem_wr = 1'b1;
      step(); step(); step();
      while (state == 3'd4 && n < 40) begin
         if (mem_wr_req) nreq++;
         n++;
         step();
      end
      total++;
      if (n !== 15 || nreq !== 15 || obs !== V_ERR) begin
         bad++; $display("FAIL timeout: waits=%0d reqs=%0d obs=%b want waits=15 reqs=15 obs=%b",
                         n, nreq, obs, V_ERR);
      end
      ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      step(); step();
      total++;
      if (obs !== V_ERR) begin bad++; $display("FAIL timeout_hold: obs=%b want %b", obs, V_ERR); end
      ready  = 1'b0;
      mem_wr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load();
      test_branch();
      test_store();
      test_halt();
      test_decode_err();
      test_reset_mid_mem();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
